// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a 1W/1R synchronous RAM.
// Latency: writes land on the accepting edge; read response valid 1 cycle after accept.
// Backpressure: req_x_ready is combinational; requesters hold their request until ready.
//
// Optional build macro: RAM_ARB_CLEAR_EN -- zeroes every RAM word after reset
// (busy high) before any request is granted.
//
// Ports:
//   clk, rst                   single clock, synchronous active-high reset
//   req_{a,b}_valid/we/addr/wdata  request from requester A / B (we=1 write)
//   req_{a,b}_ready            request accepted this cycle
//   rsp_{a,b}_valid/rdata      read response, one cycle pulse per accepted read
//   ram_wr_en/addr/data        RAM write port
//   ram_rd_en/addr, ram_rd_data  RAM read port (data registered, 1 cycle later)
//   busy                       clear sweep in progress

module ram_port_arbiter #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req_a_valid,
  input  logic                  req_a_we,
  input  logic [ADDR_WIDTH-1:0] req_a_addr,
  input  logic [DATA_WIDTH-1:0] req_a_wdata,
  output logic                  req_a_ready,

  input  logic                  req_b_valid,
  input  logic                  req_b_we,
  input  logic [ADDR_WIDTH-1:0] req_b_addr,
  input  logic [DATA_WIDTH-1:0] req_b_wdata,
  output logic                  req_b_ready,

  output logic                  rsp_a_valid,
  output logic [DATA_WIDTH-1:0] rsp_a_rdata,
  output logic                  rsp_b_valid,
  output logic [DATA_WIDTH-1:0] rsp_b_rdata,

  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,

  output logic                  busy
);

  // Elaboration-time sanity check on the geometry.
  if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_chk
    $error("ram_port_arbiter: DEPTH does not fit ADDR_WIDTH");
  end

  // run      : requests may be granted this cycle
  // clearing : write port is owned by the zeroing sweep this cycle
  logic                  run;
  logic                  clearing;
  logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef RAM_ARB_CLEAR_EN
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t state_q, state_d;

  // One bit wider than the address so DEPTH == 2**ADDR_WIDTH ends cleanly.
  logic [ADDR_WIDTH:0] clr_cnt_q, clr_cnt_d;

  localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      if (clr_cnt_q == CLR_LAST) begin
        state_d = ST_RUN;
      end else begin
        clr_cnt_d = clr_cnt_q + (ADDR_WIDTH+1)'(1);
      end
    end
  end

  // Output logic; rst gates everything combinationally so nothing is issued
  // during a reset cycle regardless of the registered state.
  always_comb begin
    run      = !rst && (state_q == ST_RUN);
    clearing = !rst && (state_q == ST_CLEAR);
    busy     = rst || (state_q == ST_CLEAR);
    clr_addr = clr_cnt_q[ADDR_WIDTH-1:0];
  end
`else
  assign run      = !rst;
  assign clearing = 1'b0;
  assign busy     = 1'b0;
  assign clr_addr = '0;
`endif

  // Round-robin pointers: 0 = A has priority, 1 = B has priority.
  logic wr_ptr_q;
  logic rd_ptr_q;

  logic wr_cand_a, wr_cand_b, rd_cand_a, rd_cand_b;
  logic wr_gnt_a,  wr_gnt_b,  rd_gnt_a,  rd_gnt_b;

  // Read response pipeline: one outstanding slot and the owner's ID (1 = B).
  logic rsp_vld_q;
  logic rsp_id_q;

  // Each requester competes on exactly one port, chosen by its we bit.
  always_comb begin
    wr_cand_a = req_a_valid &&  req_a_we;
    wr_cand_b = req_b_valid &&  req_b_we;
    rd_cand_a = req_a_valid && !req_a_we;
    rd_cand_b = req_b_valid && !req_b_we;

    wr_gnt_a  = run && wr_cand_a && (!wr_cand_b || !wr_ptr_q);
    wr_gnt_b  = run && wr_cand_b && (!wr_cand_a ||  wr_ptr_q);
    rd_gnt_a  = run && rd_cand_a && (!rd_cand_b || !rd_ptr_q);
    rd_gnt_b  = run && rd_cand_b && (!rd_cand_a ||  rd_ptr_q);

    req_a_ready = wr_gnt_a || rd_gnt_a;
    req_b_ready = wr_gnt_b || rd_gnt_b;
  end

  // RAM port muxing. The sweep and grants are mutually exclusive (run vs clearing).
  always_comb begin
    ram_wr_en   = clearing || wr_gnt_a || wr_gnt_b;
    ram_wr_addr = req_a_addr;
    ram_wr_data = req_a_wdata;
    if (clearing) begin
      ram_wr_addr = clr_addr;
      ram_wr_data = '0;
    end else if (wr_gnt_b) begin
      ram_wr_addr = req_b_addr;
      ram_wr_data = req_b_wdata;
    end

    ram_rd_en   = rd_gnt_a || rd_gnt_b;
    ram_rd_addr = rd_gnt_b ? req_b_addr : req_a_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= 1'b0;
    end else begin
      // After a grant the pointer favours the requester that lost (or was absent).
      if (wr_gnt_a || wr_gnt_b) begin
        wr_ptr_q <= wr_gnt_a;
      end
      if (rd_gnt_a || rd_gnt_b) begin
        rd_ptr_q <= rd_gnt_a;
      end
      rsp_vld_q <= ram_rd_en;
      rsp_id_q  <= rd_gnt_b;
    end
  end

  // A reset cycle drops any response still in flight.
  always_comb begin
    rsp_a_valid = rsp_vld_q && !rsp_id_q && !rst;
    rsp_b_valid = rsp_vld_q &&  rsp_id_q && !rst;
    rsp_a_rdata = ram_rd_data;
    rsp_b_rdata = ram_rd_data;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 8;

`ifdef RAM_ARB_CLEAR_EN
  localparam logic [DW-1:0] MEM_INIT = 8'hFF;
  localparam int            BUSY_RST = 1;
`else
  localparam logic [DW-1:0] MEM_INIT = 8'h00;
  localparam int            BUSY_RST = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a_valid, req_a_we, req_a_ready;
  logic [AW-1:0] req_a_addr;
  logic [DW-1:0] req_a_wdata;
  logic          req_b_valid, req_b_we, req_b_ready;
  logic [AW-1:0] req_b_addr;
  logic [DW-1:0] req_b_wdata;
  logic          rsp_a_valid, rsp_b_valid;
  logic [DW-1:0] rsp_a_rdata, rsp_b_rdata;
  logic          ram_wr_en, ram_rd_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;
  logic          busy;

  logic          tb_init;
  logic [DW-1:0] mem [DEPTH];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_a_valid(req_a_valid), .req_a_we(req_a_we), .req_a_addr(req_a_addr),
    .req_a_wdata(req_a_wdata), .req_a_ready(req_a_ready),
    .req_b_valid(req_b_valid), .req_b_we(req_b_we), .req_b_addr(req_b_addr),
    .req_b_wdata(req_b_wdata), .req_b_ready(req_b_ready),
    .rsp_a_valid(rsp_a_valid), .rsp_a_rdata(rsp_a_rdata),
    .rsp_b_valid(rsp_b_valid), .rsp_b_rdata(rsp_b_rdata),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .busy(busy)
  );

  // Behavioural 1W/1R RAM: registered read, read-before-write on same address.
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= MEM_INIT;
      ram_rd_data <= '0;
    end else begin
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tb_init = 1'b1;
    req_a_valid = 0; req_a_we = 0; req_a_addr = '0; req_a_wdata = '0;
    req_b_valid = 0; req_b_we = 0; req_b_addr = '0; req_b_wdata = '0;
    tick();
    tb_init = 1'b0;

    // ---- reset state, with a read request already waiting ----
    req_a_valid = 1; req_a_we = 0; req_a_addr = 4'd3;
    @(negedge clk);
    chk("rst_ready_a", req_a_ready, 0);
    chk("rst_rd_en",   ram_rd_en,   0);
    chk("rst_wr_en",   ram_wr_en,   0);
    chk("rst_rsp_a",   rsp_a_valid, 0);
    chk("rst_rsp_b",   rsp_b_valid, 0);
    chk("rst_busy",    busy,        BUSY_RST);
    tick();

`ifdef RAM_ARB_CLEAR_EN
    // ---- sweep interrupted by reset at address 7, then a full sweep ----
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("sweep1_busy", busy,        1);
      chk("sweep1_addr", ram_wr_addr, k);
      chk("sweep1_wen",  ram_wr_en,   1);
      chk("sweep1_rdy",  req_a_ready, 0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      chk("sweep2_busy", busy,        1);
      chk("sweep2_addr", ram_wr_addr, k);
      chk("sweep2_data", ram_wr_data, 0);
      chk("sweep2_rden", ram_rd_en,   0);
      chk("sweep2_rdy",  req_a_ready, 0);
    end
`else
    rst = 1'b0;
`endif

    // ---- first grant: A reads address 3 ----
    @(negedge clk);
    chk("t1_busy",    busy,        0);
    chk("t1_ready_a", req_a_ready, 1);
    chk("t1_rd_en",   ram_rd_en,   1);
    chk("t1_rd_addr", ram_rd_addr, 3);
    tick();
    req_a_valid = 0;
    @(negedge clk);
    chk("t1_rsp_a",   rsp_a_valid, 1);
    chk("t1_rdata",   rsp_a_rdata, 8'h00);
    chk("t1_rsp_b",   rsp_b_valid, 0);
`ifdef RAM_ARB_CLEAR_EN
    begin
      logic [DW-1:0] acc;
      acc = '0;
      for (int i = 0; i < DEPTH; i++) acc = acc | mem[i];
      chk("t1_mem_zero", acc, 0);
    end
`endif

    // ---- both write continuously: A,B,A,B ----
    tick();
    req_a_valid = 1; req_a_we = 1; req_a_addr = 4'd1; req_a_wdata = 8'h11;
    req_b_valid = 1; req_b_we = 1; req_b_addr = 4'd1; req_b_wdata = 8'h22;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_ready_a", req_a_ready, (k % 2 == 0) ? 1 : 0);
      chk("t3_ready_b", req_b_ready, (k % 2 == 0) ? 0 : 1);
      chk("t3_wr_en",   ram_wr_en,   1);
      chk("t3_wr_data", ram_wr_data, (k % 2 == 0) ? 8'h11 : 8'h22);
      tick();
    end
    req_a_valid = 0; req_b_valid = 0;
    @(negedge clk);
    chk("t3_mem1",  mem[1],    8'h22);
    chk("t3_wr_en_idle", ram_wr_en, 0);

    // ---- A writes 0x5A @2, then B reads @2 ----
    tick();
    req_a_valid = 1; req_a_we = 1; req_a_addr = 4'd2; req_a_wdata = 8'h5A;
    @(negedge clk);
    chk("t2_ready_a", req_a_ready, 1);
    chk("t2_wr_addr", ram_wr_addr, 2);
    chk("t2_wr_data", ram_wr_data, 8'h5A);
    tick();
    req_a_valid = 0;
    req_b_valid = 1; req_b_we = 0; req_b_addr = 4'd2;
    @(negedge clk);
    chk("t2_ready_b", req_b_ready, 1);
    chk("t2_rd_addr", ram_rd_addr, 2);
    tick();
    req_b_valid = 0;
    @(negedge clk);
    chk("t2_rsp_b",   rsp_b_valid, 1);
    chk("t2_rdata_b", rsp_b_rdata, 8'h5A);
    chk("t2_rsp_a",   rsp_a_valid, 0);
    tick();
    @(negedge clk);
    chk("t2_rsp_b_pulse", rsp_b_valid, 0);

    // ---- same-address write and read in one cycle ----
    tick();
    req_a_valid = 1; req_a_we = 1; req_a_addr = 4'd5; req_a_wdata = 8'h33;
    @(negedge clk);
    chk("t4_pre_ready_a", req_a_ready, 1);
    tick();
    req_a_wdata = 8'h77;
    req_b_valid = 1; req_b_we = 0; req_b_addr = 4'd5;
    @(negedge clk);
    chk("t4_ready_a", req_a_ready, 1);
    chk("t4_ready_b", req_b_ready, 1);
    chk("t4_wr_en",   ram_wr_en,   1);
    chk("t4_rd_en",   ram_rd_en,   1);
    tick();
    req_a_valid = 0;
    @(negedge clk);
    chk("t4_rsp_b",   rsp_b_valid, 1);
    chk("t4_old",     rsp_b_rdata, 8'h33);
    chk("t4_ready_b2", req_b_ready, 1);
    tick();
    req_b_valid = 0;
    @(negedge clk);
    chk("t4_new",     rsp_b_rdata, 8'h77);

    // ---- back-to-back reads A@0, B@1, A@2 ----
    for (int k = 0; k < 3; k++) begin
      tick();
      req_a_valid = 1; req_a_we = 1; req_a_addr = AW'(k); req_a_wdata = DW'(8'hA0 + k);
      @(negedge clk);
      chk("t5_fill_ready", req_a_ready, 1);
    end
    tick();
    req_a_we = 0; req_a_addr = 4'd0;
    @(negedge clk);
    chk("t5_ready_a0", req_a_ready, 1);
    tick();
    req_a_valid = 0;
    req_b_valid = 1; req_b_we = 0; req_b_addr = 4'd1;
    @(negedge clk);
    chk("t5_rsp_a0",   rsp_a_valid, 1);
    chk("t5_data_a0",  rsp_a_rdata, 8'hA0);
    chk("t5_ready_b1", req_b_ready, 1);
    tick();
    req_b_valid = 0;
    req_a_valid = 1; req_a_we = 0; req_a_addr = 4'd2;
    @(negedge clk);
    chk("t5_rsp_b1",   rsp_b_valid, 1);
    chk("t5_data_b1",  rsp_b_rdata, 8'hA1);
    chk("t5_rsp_a_off", rsp_a_valid, 0);
    chk("t5_ready_a2", req_a_ready, 1);
    tick();
    req_a_valid = 0;
    @(negedge clk);
    chk("t5_rsp_a2",   rsp_a_valid, 1);
    chk("t5_data_a2",  rsp_a_rdata, 8'hA2);
    chk("t5_rsp_b_off", rsp_b_valid, 0);

    // ---- read contention: last read grant was A, so B wins first ----
    tick();
    req_a_valid = 1; req_a_we = 0; req_a_addr = 4'd0;
    req_b_valid = 1; req_b_we = 0; req_b_addr = 4'd1;
    @(negedge clk);
    chk("t6_rd_ready_b", req_b_ready, 1);
    chk("t6_rd_ready_a", req_a_ready, 0);
    tick();
    req_b_valid = 0;
    @(negedge clk);
    chk("t6_rd_ready_a2", req_a_ready, 1);
    chk("t6_rsp_b",       rsp_b_valid, 1);
    chk("t6_data_b",      rsp_b_rdata, 8'hA1);
    tick();
    req_a_valid = 0;
    @(negedge clk);
    chk("t6_rsp_a",  rsp_a_valid, 1);
    chk("t6_data_a", rsp_a_rdata, 8'hA0);

    // ---- write contention: last write grant was A, so B wins first ----
    tick();
    req_a_valid = 1; req_a_we = 1; req_a_addr = 4'd6; req_a_wdata = 8'h66;
    req_b_valid = 1; req_b_we = 1; req_b_addr = 4'd6; req_b_wdata = 8'h99;
    @(negedge clk);
    chk("t6_wr_ready_b", req_b_ready, 1);
    chk("t6_wr_ready_a", req_a_ready, 0);
    tick();
    req_b_valid = 0;
    @(negedge clk);
    chk("t6_wr_ready_a2", req_a_ready, 1);
    tick();
    req_a_valid = 0;
    @(negedge clk);
    chk("t6_mem6", mem[6], 8'h66);

    // ---- reset with a read in flight drops the response ----
    tick();
    req_a_valid = 1; req_a_we = 0; req_a_addr = 4'd2;
    @(negedge clk);
    chk("t7_ready_a", req_a_ready, 1);
    tick();
    rst = 1'b1; req_a_valid = 0;
    @(negedge clk);
    chk("t7_rsp_dropped", rsp_a_valid, 0);
    chk("t7_busy",        busy,        BUSY_RST);
    tick();
    rst = 1'b0;
    // Pointers are back at A: simultaneous reads grant A first.
    req_a_valid = 1; req_a_we = 0; req_a_addr = 4'd0;
    req_b_valid = 1; req_b_we = 0; req_b_addr = 4'd1;
    @(negedge clk);
    for (int i = 0; i < 40 && busy === 1'b1; i++) @(negedge clk);
    chk("t7_busy_bound", busy, 0);
    chk("t7_ptr_ready_a", req_a_ready, 1);
    chk("t7_ptr_ready_b", req_b_ready, 0);
    tick();
    req_a_valid = 0; req_b_valid = 0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and sequencer in front of the dual-port (one write, one read) synchronous RAM. It shares the RAM's write port and read port between requesters A and B using independent round-robin arbiters, returns read data with a registered valid flag, and can optionally zero the whole RAM after reset before accepting traffic. It sits directly between the RAM instance and its clients; the RAM parameters pass through unchanged.

## Interface
- DEPTH, 16, number of RAM words
- ADDR_WIDTH, 4, address width (DEPTH ≤ 2^ADDR_WIDTH)
- DATA_WIDTH, 8, data word width

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_a_valid / req_b_valid  in  1  request present
- req_a_we / req_b_we  in  1  1 = write, 0 = read
- req_a_addr / req_b_addr  in  ADDR_WIDTH  word address
- req_a_wdata / req_b_wdata  in  DATA_WIDTH  write data
- req_a_ready / req_b_ready  out  1  request accepted this cycle (combinational)
- rsp_a_valid / rsp_b_valid  out  1  read data valid for that requester
- rsp_a_rdata / rsp_b_rdata  out  DATA_WIDTH  read data
- ram_wr_en, ram_wr_addr, ram_wr_data  out  1/ADDR_WIDTH/DATA_WIDTH  RAM write port
- ram_rd_en, ram_rd_addr  out  1/ADDR_WIDTH  RAM read port
- ram_rd_data  in  DATA_WIDTH  RAM registered read data (valid 1 cycle after ram_rd_en)
- busy  out  1  clear sweep in progress

## Operation
- Handshake: transfer occurs when valid && ready. Requesters hold valid, we, addr, wdata stable until accepted, and valid does not depend on ready.
- Write port arbiter: candidates are requesters with valid && we. Read port arbiter: candidates with valid && !we. The two arbiters are independent, so one write and one read are granted in the same cycle.
- Round-robin per port: a 1-bit priority pointer per port. On contention the pointed-to requester wins. After any grant on that port, the pointer moves to the other requester. A lone candidate is always granted and still moves the pointer. Both pointers reset to A.
- Write grant drives ram_wr_en=1, ram_wr_addr/ram_wr_data from the winner, in the same cycle.
- Read grant drives ram_rd_en=1, ram_rd_addr from the winner, and registers the winner's ID. On the next cycle the arbiter asserts that requester's rsp_x_valid for exactly 1 cycle. rsp_a_rdata and rsp_b_rdata both carry ram_rd_data and are meaningful only while their valid is set.
- Reads are pipelined: one read is accepted per cycle, and responses return in acceptance order.
- Same-address write and read in the same cycle: the read returns the old contents (read-before-write). No forwarding is done.
- States: CLEAR (only with the macro) and RUN. In CLEAR both readies are 0, the read port is idle, and the write port writes 0 to address clr_cnt, counting 0..DEPTH-1. After DEPTH-1 is written the arbiter moves to RUN.

## Timing
- While rst=1: req_x_ready=0, ram_wr_en=0, ram_rd_en=0, rsp_x_valid=0, pointers=A. busy=1 with the macro, 0 without.
- First cycle after rst deasserts: RUN accepts immediately (no macro). With the macro, CLEAR runs for DEPTH cycles (addresses 0..DEPTH-1) and the first grant comes in cycle DEPTH.
- Read latency is 1 cycle from the accept edge to rsp_x_valid.
- Write latency is 0 cycles: the write lands on the same edge that accepts it.
- Reset asserted mid-sweep: the sweep restarts at address 0.
- Reset asserted with a read in flight: the pending rsp_x_valid is dropped (forced 0).
- clr_cnt is ADDR_WIDTH+1 bits wide so that DEPTH = 2^ADDR_WIDTH terminates without wrapping.

## Configuration
- RAM_ARB_CLEAR_EN defined: the CLEAR state, clr_cnt and the zeroing sweep are compiled in. busy is high during the sweep.
- RAM_ARB_CLEAR_EN undefined: no CLEAR state and no counter. busy is tied to 0, and the arbiter is in RUN directly after reset. RAM contents after reset are undefined.

## Test plan
- Reset, then read addr 3 from A (macro on): busy high 16 cycles, then rsp_a_valid one cycle after accept with rdata=0x00.
- A writes 0x5A to addr 2, then B reads addr 2: B's ready is high on the request cycle, rsp_b_valid arrives the following cycle with rdata=0x5A, and rsp_a_valid stays 0.
- A and B both write continuously (A: addr 1/0x11, B: addr 1/0x22): grants alternate A,B,A,B starting with A, and ram_wr_en stays high every cycle.
- A writes 0x77 to addr 5 while B reads addr 5 (old value 0x33) in the same cycle: both are accepted, B receives 0x33, and a later read returns 0x77.
- Back-to-back reads A addr 0, B addr 1, A addr 2 (values 0xA0/0xA1/0xA2): responses arrive on consecutive cycles to A, B, A with matching data.
- Assert rst at sweep address 7: the sweep restarts at 0 and busy stays high for a further 16 cycles after rst deasserts.
